// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Walks an address range of the register file through a shared read
//            port and streams {addr, data} words over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] last_q;
    logic              handshake;

    assign handshake = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = WAIT;
            WAIT: state_nxt = abort ? IDLE : SEND;
            SEND: begin
                // Abort wins over a coincident handshake: the word is dropped.
                if (abort)
                    state_nxt = IDLE;
                else if (handshake)
                    state_nxt = (rd_addr == last_q) ? DONE : WAIT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // busy/done are flops tracking the next state so outputs stay registered.
            busy <= (state_nxt == WAIT) || (state_nxt == SEND);
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        last_q  <= last_reg;
                        rd_addr <= first_reg;
                    end
                end
                WAIT: begin
                    if (!abort) begin
                        out_data  <= rd_data;
                        out_addr  <= rd_addr;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                        if (rd_addr != last_q)
                            rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Purpose  : Directed self-checking bench with a behavioural 32x32 register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    assign rd_data = regs[rd_addr];

    int errors = 0;
    int checks = 0;

    int          nwords, busy_cycles, done_pulses, done_at;
    logic [4:0]  got_addr [64];
    logic [31:0] got_data [64];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a dump and serves it with ready high, except for an optional
    // stall of stall_cycles on word index stall_word. Samples on falling edges.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int stall_word, input int stall_cycles);
        int         widx;
        int         stall_left;
        logic [4:0] ea;
        widx = 0;
        stall_left = stall_cycles;
        nwords = 0; busy_cycles = 0; done_pulses = 0; done_at = 0;
        first_reg = f; last_reg = l; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (done_at == 0) done_at = cyc;
            end
            if (done_at != 0 && cyc >= done_at + 2) break;
            ea = f + 5'(widx);
            if (out_valid) begin
                check("word_addr", 64'(out_addr), 64'(ea));
                check("word_data", 64'(out_data), 64'(regs[ea]));
                if (widx == stall_word && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    if (widx < 64) begin
                        got_addr[widx] = out_addr;
                        got_data[widx] = out_data;
                    end
                    widx++;
                end
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        nwords = widx;
        check("dump_finished", 64'(done_at != 0), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[8] = 32'd10; regs[9] = 32'd20; regs[10] = 32'd22;
        regs[16] = 32'd1; regs[23] = 32'd8;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_rdaddr", 64'(rd_addr), 64'd0);
        check("rst_outaddr", 64'(out_addr), 64'd0);
        check("rst_outdata", 64'(out_data), 64'd0);

        // Full dump 0..31
        run_dump(5'd0, 5'd31, -1, 0);
        check("full_nwords", 64'(nwords), 64'd32);
        check("full_busy",   64'(busy_cycles), 64'd64);
        check("full_done_at", 64'(done_at), 64'd65);
        check("full_done_pulses", 64'(done_pulses), 64'd1);
        check("full_a8",  64'(got_data[8]),  64'd10);
        check("full_a9",  64'(got_data[9]),  64'd20);
        check("full_a10", 64'(got_data[10]), 64'd22);
        check("full_a16", 64'(got_data[16]), 64'd1);
        check("full_a23", 64'(got_data[23]), 64'd8);
        check("full_a0",  64'(got_data[0]),  64'd0);
        check("full_last_addr", 64'(got_addr[31]), 64'd31);

        // Single word
        run_dump(5'd9, 5'd9, -1, 0);
        check("single_nwords", 64'(nwords), 64'd1);
        check("single_addr", 64'(got_addr[0]), 64'd9);
        check("single_data", 64'(got_data[0]), 64'd20);
        check("single_busy", 64'(busy_cycles), 64'd2);
        check("single_done_pulses", 64'(done_pulses), 64'd1);

        // Wrap range 30 -> 1
        run_dump(5'd30, 5'd1, -1, 0);
        check("wrap_nwords", 64'(nwords), 64'd4);
        check("wrap_a0", 64'(got_addr[0]), 64'd30);
        check("wrap_a1", 64'(got_addr[1]), 64'd31);
        check("wrap_a2", 64'(got_addr[2]), 64'd0);
        check("wrap_a3", 64'(got_addr[3]), 64'd1);

        // Backpressure on the second word
        run_dump(5'd8, 5'd10, 1, 3);
        check("bp_nwords", 64'(nwords), 64'd3);
        check("bp_busy", 64'(busy_cycles), 64'd9);
        check("bp_done_at", 64'(done_at), 64'd10);
        check("bp_word1", 64'(got_data[1]), 64'd20);

        // Abort coincident with a handshake on word 2
        first_reg = 5'd0; last_reg = 5'd31; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int found;
            found = 0;
            for (int i = 0; i < 20; i++) begin
                if (out_valid && out_addr == 5'd2) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
            end
            check("abort_reached_word2", 64'(found), 64'd1);
        end
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        begin
            int dseen;
            dseen = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done || busy) dseen++;
            end
            check("abort_idle_quiet", 64'(dseen), 64'd0);
        end

        // Fresh dump after abort
        run_dump(5'd8, 5'd10, -1, 0);
        check("post_abort_nwords", 64'(nwords), 64'd3);
        check("post_abort_w2", 64'(got_data[2]), 64'd22);

        // Reset while in SEND
        first_reg = 5'd8; last_reg = 5'd20; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_data", 64'(out_data), 64'd10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_rdaddr", 64'(rd_addr), 64'd0);
        check("midrst_outaddr", 64'(out_addr), 64'd0);
        check("midrst_outdata", 64'(out_data), 64'd0);
        @(negedge clk);
        check("midrst_no_done", 64'(done), 64'd0);

        // Coherence: write after the snapshot edge is not reflected
        regs[12] = 32'd50;
        first_reg = 5'd12; last_reg = 5'd12; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("coh_valid", 64'(out_valid), 64'd1);
        regs[12] = 32'h55;
        @(negedge clk);
        check("coh_snapshot", 64'(out_data), 64'd50);
        out_ready = 1'b1;
        @(negedge clk);
        check("coh_done", 64'(done), 64'd1);
        @(negedge clk);
        run_dump(5'd12, 5'd12, -1, 0);
        check("coh_second", 64'(got_data[0]), 64'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
